i2c_codec_target: RTL and testbench

- Synchronous I2C target (responder) for the 3-byte codec register-write frame: device address + R/W, then 7-bit register + data[8], then data[7:0].
- Oversamples SDCLK/SDAT in the system clock domain, detects START/STOP and ACKs matching frames by pulling SDAT low.
- Emits a one-cycle register-write strobe.
- Used as a codec model in simulation and as an on-FPGA configuration sink fed by our I2C controller.

---
 rtl/i2c_codec_target.sv | 174 +++++++++++++++++
 tb/tb_i2c_codec_target.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_target.sv
// I2C target for the 3-byte codec register-write frame (addr+rw, reg+data[8], data[7:0]).
// Optional input glitch filter: define I2C_CODEC_TARGET_GLITCH_FILTER_EN.
module i2c_codec_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SDCLK,
    inout  wire        SDAT,
    output logic       wr_valid,
    output logic [6:0] wr_reg,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic [1:0] error
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_B1, S_ACK_1, S_B2, S_ACK_2, S_DONE, S_IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_p, sda_p;
    logic [3:0]             cnt;
    logic [7:0]             sh;
    logic [6:0]             reg_hold;
    logic                   d8_hold;
    logic                   drive_low;

    assign SDAT = drive_low ? 1'b0 : 1'bz;

    // Synchronisers; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SDCLK};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDAT};
        end
    end

`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;
    logic       scl_f, sda_f;
    logic       scl_in, sda_in;

    assign scl_in = scl_sync[SYNC_STAGES-1];
    assign sda_in = sda_sync[SYNC_STAGES-1];

    // 3-sample majority vote rejects single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_h <= '1;
            sda_h <= '1;
            scl_f <= 1'b1;
            sda_f <= 1'b1;
        end else begin
            scl_h <= {scl_h[0], scl_in};
            sda_h <= {sda_h[0], sda_in};
            scl_f <= (scl_in & scl_h[0]) | (scl_in & scl_h[1]) | (scl_h[0] & scl_h[1]);
            sda_f <= (sda_in & sda_h[0]) | (sda_in & sda_h[1]) | (sda_h[0] & sda_h[1]);
        end
    end

    assign scl_s = scl_f;
    assign sda_s = sda_f;
`else
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_s;
            sda_p <= sda_s;
        end
    end

    // SDCLK must be high in both samples, so coincident edges never flag START/STOP.
    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = ~scl_p & scl_s;
    assign scl_fall  = scl_p & ~scl_s;
    assign start_det = scl_p & scl_s & sda_p & ~sda_s;
    assign stop_det  = scl_p & scl_s & ~sda_p & sda_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            sh        <= 8'd0;
            reg_hold  <= 7'd0;
            d8_hold   <= 1'b0;
            drive_low <= 1'b0;
            wr_valid  <= 1'b0;
            wr_reg    <= 7'd0;
            wr_data   <= 9'd0;
            busy      <= 1'b0;
            error     <= 2'd0;
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                state     <= S_ADDR;
                cnt       <= 4'd0;
                drive_low <= 1'b0;
                busy      <= 1'b1;
            end else if (stop_det) begin
                if ((state == S_ADDR && cnt != 4'd0) || state == S_ACK_A || state == S_B1 ||
                    state == S_ACK_1 || state == S_B2)
                    error <= 2'd1;
                state     <= S_IDLE;
                cnt       <= 4'd0;
                drive_low <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_B1, S_B2, S_DONE: begin
                        if (scl_rise) begin
                            sh  <= {sh[6:0], sda_s};
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            cnt <= 4'd0;
                            case (state)
                                S_ADDR: begin
                                    if (sh == {DEV_ADDR, 1'b0}) begin
                                        state     <= S_ACK_A;
                                        drive_low <= 1'b1;
                                    end else begin
                                        state <= S_IGNORE;
                                    end
                                end
                                S_B1: begin
                                    reg_hold  <= sh[7:1];
                                    d8_hold   <= sh[0];
                                    state     <= S_ACK_1;
                                    drive_low <= 1'b1;
                                end
                                S_B2: begin
                                    wr_reg    <= reg_hold;
                                    wr_data   <= {d8_hold, sh};
                                    wr_valid  <= 1'b1;
                                    state     <= S_ACK_2;
                                    drive_low <= 1'b1;
                                end
                                default: begin
                                    error <= 2'd2;
                                    state <= S_IGNORE;
                                end
                            endcase
                        end
                    end
                    // ACK bit ends on the next SDCLK falling edge.
                    S_ACK_A, S_ACK_1, S_ACK_2: begin
                        if (scl_fall) begin
                            drive_low <= 1'b0;
                            cnt       <= 4'd0;
                            case (state)
                                S_ACK_A: state <= S_B1;
                                S_ACK_1: state <= S_B2;
                                default: state <= S_DONE;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Scoreboard bench for i2c_codec_target: an I2C initiator model drives frames,
// expected register writes are queued and popped by a wr_valid monitor.
module tb_i2c_codec_target;

    localparam int unsigned Q = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        SDAT;
    logic       wr_valid;
    logic [6:0] wr_reg;
    logic [8:0] wr_data;
    logic       busy;
    logic [1:0] error;

    typedef struct packed {
        logic [6:0] r;
        logic [8:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    assign SDAT = m_low ? 1'b0 : 1'bz;
    pullup (SDAT);

    always #5 clk = ~clk;

    i2c_codec_target #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SDCLK(scl), .SDAT(SDAT),
        .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data),
        .busy(busy), .error(error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        m_low = 1'b1; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        m_low = 1'b0; tick(Q);
    endtask

    task automatic send_bit(input logic b, input logic spike);
        m_low = ~b;
        tick(Q / 2);
        if (spike) begin
            scl = 1'b1; tick(1);
            scl = 1'b0;
        end
        tick(Q / 2);
        scl = 1'b1; tick(2 * Q);
        scl = 1'b0; tick(Q);
    endtask

    // spike_idx selects a bit (7..0) that gets a 1-clk SDCLK pulse; -1 for none.
    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name,
                             input int spike_idx);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == spike_idx);
        m_low = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        chk(name, 32'(SDAT), 32'(exp_ack));
        tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    // Monitor: every wr_valid cycle must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && wr_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr_valid actual reg=%0h data=%0h required none",
                         wr_reg, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_reg", 32'(wr_reg), 32'(e.r));
                chk("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

    initial begin
        tick(5);
        rst = 1'b0;
        tick(2);
        chk("rst_sdat", 32'(SDAT), 32'd1);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_reg", 32'(wr_reg), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);

        // Valid frame: reg 0x07, data 0x0A5.
        exp_q.push_back('{r: 7'h07, d: 9'h0A5});
        i2c_start();
        chk("t1_busy", 32'(busy), 32'd1);
        send_byte(8'h34, 1'b0, "t1_ack_a", -1);
        send_byte(8'h0E, 1'b0, "t1_ack_1", -1);
        send_byte(8'hA5, 1'b0, "t1_ack_2", -1);
        i2c_stop();
        tick(10);
        chk("t1_busy_after_stop", 32'(busy), 32'd0);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_reg_held", 32'(wr_reg), 32'h07);
        chk("t1_data_held", 32'(wr_data), 32'h0A5);

        // Wrong address: NACK, payload ignored.
        i2c_start();
        send_byte(8'h36, 1'b1, "t2_nack_a", -1);
        send_byte(8'h0E, 1'b1, "t2_nack_1", -1);
        send_byte(8'hA5, 1'b1, "t2_nack_2", -1);
        chk("t2_busy_ignore", 32'(busy), 32'd1);
        i2c_stop();
        tick(10);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_error", 32'(error), 32'd0);

        // Read request: NACK.
        i2c_start();
        send_byte(8'h35, 1'b1, "t3_nack_rw", -1);
        i2c_stop();
        tick(10);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_error", 32'(error), 32'd0);

        // STOP after B1 sets error=1; next frame still accepted.
        i2c_start();
        send_byte(8'h34, 1'b0, "t4_ack_a", -1);
        send_byte(8'h0E, 1'b0, "t4_ack_1", -1);
        i2c_stop();
        tick(10);
        chk("t4_error_short", 32'(error), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        exp_q.push_back('{r: 7'h09, d: 9'h001});
        i2c_start();
        send_byte(8'h34, 1'b0, "t4b_ack_a", -1);
        send_byte(8'h12, 1'b0, "t4b_ack_1", -1);
        send_byte(8'h01, 1'b0, "t4b_ack_2", -1);
        i2c_stop();
        tick(10);
        chk("t4b_error_sticky", 32'(error), 32'd1);

        // Repeated START mid-B2, full frame, then an extra byte.
        i2c_start();
        send_byte(8'h34, 1'b0, "t5_ack_a", -1);
        send_byte(8'h0E, 1'b0, "t5_ack_1", -1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        exp_q.push_back('{r: 7'h04, d: 9'h179});
        i2c_start();
        chk("t5_busy_rs", 32'(busy), 32'd1);
        chk("t5_error_rs", 32'(error), 32'd1);
        send_byte(8'h34, 1'b0, "t5b_ack_a", -1);
        send_byte(8'h09, 1'b0, "t5b_ack_1", -1);
        send_byte(8'h79, 1'b0, "t5b_ack_2", -1);
        send_byte(8'hFF, 1'b1, "t5b_nack_extra", -1);
        i2c_stop();
        tick(10);
        chk("t5_error_extra", 32'(error), 32'd2);
        chk("t5_busy", 32'(busy), 32'd0);

        // rst during ACK_1 releases SDAT and clears outputs.
        i2c_start();
        send_byte(8'h34, 1'b0, "t6_ack_a", -1);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h0E >> i), 1'b0);
        m_low = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        chk("t6_ack_1_driven", 32'(SDAT), 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_sdat_released", 32'(SDAT), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_error", 32'(error), 32'd0);
        chk("t6_wr_reg", 32'(wr_reg), 32'd0);
        chk("t6_wr_data", 32'(wr_data), 32'd0);
        chk("t6_wr_valid", 32'(wr_valid), 32'd0);
        tick(Q);
        scl = 1'b0; tick(Q);
        i2c_stop();
        tick(10);
        chk("t6_error_after_stop", 32'(error), 32'd0);

`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
        // 1-clk SDCLK spike mid-B1 must be filtered out: reg 0x0B, data 0x155.
        exp_q.push_back('{r: 7'h0B, d: 9'h155});
        i2c_start();
        send_byte(8'h34, 1'b0, "t7_ack_a", -1);
        send_byte(8'h17, 1'b0, "t7_ack_1", 4);
        send_byte(8'h55, 1'b0, "t7_ack_2", -1);
        i2c_stop();
        tick(10);
        chk("t7_error", 32'(error), 32'd0);
`endif

        tick(20);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
